// File: rtl/spi_reg_responder.sv
// ---------------------------------------------------------------------------
// spi_reg_responder
//
// SPI mode-0 responder for a host master. SCLK, MOSI and CS are oversampled
// in the sysclk domain and decoded into 2-byte frames (command byte followed
// by a data byte). Writes are presented to the register bank as a one-cycle
// strobe; reads drive a read address and capture the bank's combinational
// read data into a transmit shift register that is clocked out on MISO.
//
// Command byte: bit 7 = read (1) / write (0), bits [ADDR_W-1:0] = address,
// remaining bits are ignored.
//
// Configuration macro:
//   SPI_REG_RESPONDER_AUTOINC_EN  burst mode: the frame stays in the data
//                                 phase after each byte and the address
//                                 increments (wrapping). Undefined: one data
//                                 byte per frame, extra bits are ignored.
//
// Parameters:
//   ADDR_W       register address width (1..7)
//   SYNC_STAGES  synchronizer depth on the SPI inputs (>= 2)
//
// Ports:
//   sysclk       block clock, rising edge
//   reset_INV    asynchronous active-low reset
//   spi_clk      SCLK from the master (asynchronous, <= sysclk/8)
//   spi_mosi     master-out data (asynchronous)
//   spi_cs_INV   active-low chip select (asynchronous)
//   spi_miso     registered slave-out data
//   spi_miso_oe  MISO output enable, high while selected
//   wr_en        one-cycle write strobe
//   wr_addr      write address, valid with wr_en
//   wr_data      write data, valid with wr_en
//   rd_addr      read address to the register bank
//   rd_data      register bank read data (combinational from rd_addr)
//   rd_strobe    one-cycle pulse in the cycle rd_data is captured
//   frame_err    one-cycle pulse when CS rises in the middle of a byte
//   busy         high while a frame is in progress
// ---------------------------------------------------------------------------
module spi_reg_responder #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sysclk,
    input  logic              reset_INV,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs_INV,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              rd_strobe,
    output logic              frame_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   clk_d;
    logic                   cs_d;

    logic                   sclk_s;
    logic                   mosi_s;
    logic                   cs_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_rise;
    logic                   cs_fall;
    logic                   byte_edge;
    logic                   in_frame;

    logic [2:0]             bit_cnt;
    logic [6:0]             shift_rx;
    logic [7:0]             rx_next;
    logic [6:0]             tx_shift;
    logic                   rd_flag;
    logic [ADDR_W-1:0]      addr;

    assign sclk_s    = clk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~clk_d;
    assign sclk_fall = ~sclk_s & clk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign byte_edge = sclk_rise && (bit_cnt == 3'd7);
    assign in_frame  = (state == ST_CMD) || (state == ST_DATA);
    assign rx_next   = {shift_rx, mosi_s};

    // Synchronizers plus one extra flop on SCLK and CS for edge detection.
    // The CS chain resets to "selected" (0) so that ARM only leaves once a
    // genuine high level has been seen on the pin, never mid-stream.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            clk_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            clk_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_INV};
            clk_d     <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // Frame state register.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            state <= ST_ARM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A CS rise ends any frame and takes priority over a
    // coincident byte-completing SCLK edge.
    always_comb begin
        state_next = state;
        case (state)
            ST_ARM: begin
                if (cs_s) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else if (byte_edge) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else if (byte_edge) begin
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
                    state_next = ST_DATA;
`else
                    state_next = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_ARM;
        endcase
    end

    // Datapath: byte shifting, command decode, strobes and MISO.
    // rd_strobe is raised on the byte-completing edge, so the cycle in which
    // it is high is the one where rd_addr is stable and rd_data is captured.
    // In DATA the first SCLK fall (bit_cnt == 0) belongs to the previous
    // byte and must not shift, otherwise the freshly loaded bit 7 is lost.
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_addr     <= '0;
            rd_strobe   <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            shift_rx    <= '0;
            tx_shift    <= '0;
            rd_flag     <= 1'b0;
            addr        <= '0;
        end else begin
            wr_en     <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (cs_rise) begin
                busy        <= 1'b0;
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
                bit_cnt     <= '0;
                if (in_frame && (bit_cnt != 3'd0)) begin
                    frame_err <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            busy        <= 1'b1;
                            spi_miso_oe <= 1'b1;
                            spi_miso    <= 1'b0;
                            bit_cnt     <= '0;
                            rd_flag     <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            shift_rx <= rx_next[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rd_flag <= rx_next[7];
                                addr    <= rx_next[ADDR_W-1:0];
                                if (rx_next[7]) begin
                                    rd_addr   <= rx_next[ADDR_W-1:0];
                                    rd_strobe <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rd_strobe) begin
                            tx_shift <= rd_data[6:0];
                            spi_miso <= rd_data[7];
                        end else if (sclk_fall && rd_flag && (bit_cnt != 3'd0)) begin
                            spi_miso <= tx_shift[6];
                            tx_shift <= {tx_shift[5:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            shift_rx <= rx_next[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (!rd_flag) begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= addr;
                                    wr_data <= rx_next;
                                end
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
                                addr <= addr + ADDR_W'(1);
                                if (rd_flag) begin
                                    rd_addr   <= addr + ADDR_W'(1);
                                    rd_strobe <= 1'b1;
                                end
`else
                                spi_miso <= 1'b0;
`endif
                            end
                        end
                    end
                    ST_DONE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_responder
//
// Directed and random SPI frames against spi_reg_responder. A register bank
// model supplies rd_data; expected writes, reads and MISO bytes are pushed to
// scoreboard queues when a frame is driven and popped after the frame ends.
// Honours SPI_REG_RESPONDER_AUTOINC_EN for the burst expectations.
// ---------------------------------------------------------------------------
module tb_spi_reg_responder;

    localparam int ADDR_W      = 4;
    localparam int SYNC_STAGES = 2;

    logic              sysclk     = 1'b0;
    logic              reset_INV  = 1'b0;
    logic              spi_clk    = 1'b0;
    logic              spi_mosi   = 1'b0;
    logic              spi_cs_INV = 1'b1;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              rd_strobe;
    logic              frame_err;
    logic              busy;

    logic [7:0] bank [16];

    assign rd_data = bank[rd_addr];

    spi_reg_responder #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .sysclk      (sysclk),
        .reset_INV   (reset_INV),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_cs_INV  (spi_cs_INV),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_strobe   (rd_strobe),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;

    // Free-running cycle count used for latency measurement.
    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Monitor: log every strobe seen on the DUT outputs.
    int                wr_cnt = 0;
    int                rd_cnt = 0;
    int                err_cnt = 0;
    logic [ADDR_W-1:0] obs_wr_addr [256];
    logic [7:0]        obs_wr_data [256];
    int                obs_wr_cyc  [256];
    logic [ADDR_W-1:0] obs_rd_addr [256];

    always @(negedge sysclk) begin
        if (wr_en && (wr_cnt < 256)) begin
            obs_wr_addr[wr_cnt] = wr_addr;
            obs_wr_data[wr_cnt] = wr_data;
            obs_wr_cyc[wr_cnt]  = cyc;
            wr_cnt = wr_cnt + 1;
        end
        if (rd_strobe && (rd_cnt < 256)) begin
            obs_rd_addr[rd_cnt] = rd_addr;
            rd_cnt = rd_cnt + 1;
        end
        if (frame_err) begin
            err_cnt = err_cnt + 1;
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_item_t;

    wr_item_t          exp_wr_q   [$];
    logic [ADDR_W-1:0] exp_rd_q   [$];
    logic [7:0]        exp_miso_q [$];
    logic [7:0]        obs_miso_q [$];

    int wr_seen    = 0;
    int rd_seen    = 0;
    int err_seen   = 0;
    int edge16_cyc = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total = total + 1;
        assert (observed === expected) else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One SCLK period at sysclk/8: MISO is sampled just before the rising edge.
    task automatic sclk_bit(input logic b, input logic cs_rise_too,
                            output logic sampled, output int rise_cyc);
        spi_mosi = b;
        repeat (4) @(negedge sysclk);
        sampled  = spi_miso;
        spi_clk  = 1'b1;
        rise_cyc = cyc;
        if (cs_rise_too) spi_cs_INV = 1'b1;
        repeat (4) @(negedge sysclk);
        spi_clk = 1'b0;
    endtask

    // Drive one frame of n_edges bits from {cmd, d0, d1}; when model_en is set
    // the expected bank traffic is pushed to the scoreboard.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] d0,
                                 input logic [7:0] d1, input int n_edges,
                                 input bit model_en, input bit cs_with_last);
        logic [23:0]       stream;
        logic [ADDR_W-1:0] a;
        logic [7:0]        m0;
        logic [7:0]        m1;
        logic              s;
        int                rc;
        int                nbytes;
        stream = {cmd, d0, d1};
        a      = cmd[ADDR_W-1:0];
        nbytes = n_edges / 8;
        m0     = 8'h00;
        m1     = 8'h00;
        if (model_en) begin
            if (cmd[7]) begin
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
                for (int k = 0; k < nbytes; k++) exp_rd_q.push_back(a + ADDR_W'(k));
                if (nbytes >= 3) exp_miso_q.push_back(bank[a + ADDR_W'(1)]);
`else
                if (nbytes >= 1) exp_rd_q.push_back(a);
                if (nbytes >= 3) exp_miso_q.push_back(8'h00);
`endif
                if (nbytes >= 2) exp_miso_q.push_back(bank[a]);
            end else begin
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
                if (nbytes >= 2) exp_wr_q.push_back('{a, d0});
                if (nbytes >= 3) exp_wr_q.push_back('{a + ADDR_W'(1), d1});
`else
                if (nbytes >= 2) exp_wr_q.push_back('{a, d0});
`endif
            end
        end
        spi_cs_INV = 1'b0;
        repeat (4) @(negedge sysclk);
        checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
        checkOutput("oe_in_frame", {31'd0, spi_miso_oe}, 32'd1);
        for (int i = 0; i < n_edges; i++) begin
            sclk_bit(stream[23-i], cs_with_last && (i == n_edges - 1), s, rc);
            if (i >= 8 && i < 16) m0[15-i] = s;
            if (i >= 16) m1[23-i] = s;
            if (i == 15) edge16_cyc = rc;
        end
        repeat (4) @(negedge sysclk);
        spi_cs_INV = 1'b1;
        repeat (8) @(negedge sysclk);
        if (model_en && cmd[7]) begin
            if (nbytes >= 3) obs_miso_q.push_back(m1);
            if (nbytes >= 2) obs_miso_q.push_back(m0);
        end
    endtask

    // Compare the monitor log and MISO bytes of the last frame with the queues.
    task automatic drain(input string tag, input int exp_err);
        wr_item_t          e;
        logic [ADDR_W-1:0] ra;
        checkOutput({tag, "_wr_count"}, wr_cnt - wr_seen, exp_wr_q.size());
        while (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            if (wr_seen < wr_cnt) begin
                checkOutput({tag, "_wr_addr"}, {28'd0, obs_wr_addr[wr_seen]}, {28'd0, e.addr});
                checkOutput({tag, "_wr_data"}, {24'd0, obs_wr_data[wr_seen]}, {24'd0, e.data});
            end
            wr_seen = wr_seen + 1;
        end
        wr_seen = wr_cnt;
        checkOutput({tag, "_rd_count"}, rd_cnt - rd_seen, exp_rd_q.size());
        while (exp_rd_q.size() > 0) begin
            ra = exp_rd_q.pop_front();
            if (rd_seen < rd_cnt) begin
                checkOutput({tag, "_rd_addr"}, {28'd0, obs_rd_addr[rd_seen]}, {28'd0, ra});
            end
            rd_seen = rd_seen + 1;
        end
        rd_seen = rd_cnt;
        while (exp_miso_q.size() > 0 && obs_miso_q.size() > 0) begin
            checkOutput({tag, "_miso"}, {24'd0, obs_miso_q.pop_back()},
                        {24'd0, exp_miso_q.pop_back()});
        end
        exp_miso_q.delete();
        obs_miso_q.delete();
        checkOutput({tag, "_frame_err"}, err_cnt - err_seen, exp_err);
        err_seen = err_cnt;
    endtask

    initial begin
        logic [23:0] stream;
        logic        s;
        int          rc;
        int          lat;
        logic [7:0]  rc_cmd;
        logic [7:0]  rc_dat;

        for (int i = 0; i < 16; i++) bank[i] = 8'($urandom_range(0, 255));
        bank[3] = 8'h5C;

        // Reset state.
        reset_INV  = 1'b0;
        spi_cs_INV = 1'b1;
        repeat (3) @(negedge sysclk);
        checkOutput("rst_miso", {31'd0, spi_miso}, 32'd0);
        checkOutput("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        checkOutput("rst_wr_data", {24'd0, wr_data}, 32'd0);
        checkOutput("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
        checkOutput("rst_rd_strobe", {31'd0, rd_strobe}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        reset_INV = 1'b1;
        repeat (6) @(negedge sysclk);

        // Write frame with latency measurement.
        applyStimulus(8'h05, 8'hA7, 8'h00, 16, 1'b1, 1'b0);
        lat = (wr_cnt > wr_seen) ? (obs_wr_cyc[wr_seen] - edge16_cyc) : -1;
        checkOutput("wr_latency", lat, SYNC_STAGES + 1);
        drain("write", 0);

        // Read frame from address 3.
        applyStimulus(8'h83, 8'h00, 8'h00, 16, 1'b1, 1'b0);
        drain("read", 0);

        // Write aborted after 11 edges.
        applyStimulus(8'h06, 8'h99, 8'h00, 11, 1'b0, 1'b0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_oe", {31'd0, spi_miso_oe}, 32'd0);
        checkOutput("abort_miso", {31'd0, spi_miso}, 32'd0);
        drain("abort", 1);

        // CS rises together with the 16th SCLK edge: CS wins.
        applyStimulus(8'h07, 8'h42, 8'h00, 16, 1'b0, 1'b1);
        drain("cs_vs_edge", 1);

        // Reset mid-frame, released with CS still low.
        stream     = {8'h02, 8'h44, 8'h00};
        spi_cs_INV = 1'b0;
        repeat (4) @(negedge sysclk);
        for (int i = 0; i < 5; i++) sclk_bit(stream[23-i], 1'b0, s, rc);
        @(negedge sysclk);
        reset_INV = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_oe", {31'd0, spi_miso_oe}, 32'd0);
        @(negedge sysclk);
        reset_INV = 1'b1;
        for (int i = 5; i < 16; i++) sclk_bit(stream[23-i], 1'b0, s, rc);
        repeat (4) @(negedge sysclk);
        spi_cs_INV = 1'b1;
        repeat (8) @(negedge sysclk);
        drain("midrst", 0);
        applyStimulus(8'h01, 8'h33, 8'h00, 16, 1'b1, 1'b0);
        drain("recover", 0);

        // Three-byte frame: burst with wrap, or second byte ignored.
        applyStimulus(8'h0F, 8'h11, 8'h22, 24, 1'b1, 1'b0);
        drain("burst", 0);

        // Random frames against the model.
        for (int n = 0; n < 100; n++) begin
            rc_cmd = 8'($urandom_range(0, 255));
            rc_dat = 8'($urandom_range(0, 255));
            applyStimulus(rc_cmd, rc_dat, 8'h00, 16, 1'b1, 1'b0);
            drain("rand", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
